// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: widths, reset PC, instruction field
// positions and the fetch FSM state encoding.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

  localparam int OPCODE_LSB = 0;
  localparam int RD_LSB     = 7;
  localparam int FUNCT3_LSB = 12;
  localparam int RS1_LSB    = 15;
  localparam int RS2_LSB    = 20;
  localparam int FUNCT7_LSB = 25;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/if_fifo.sv
// Synchronous FIFO holding {pc, instruction} pairs between fetch and decode.
// Head data reads as zero while empty so downstream fields are quiet.
module if_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; validity comes from count, so clearing the
  // array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && full && !flush));

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, single-outstanding imem request FSM with
// redirect/drain, and a small FIFO presenting pre-sliced fields to decode.
module if_stage
  import riscv_pkg::*;
#(
  parameter int                    XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0]       RESET_PC = riscv_pkg::RESET_PC,
  parameter int                    DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_pc,
  output logic [XLEN-1:0] inst,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [2:0]      funct3,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [6:0]      funct7
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_e      state, state_n;
  logic [XLEN-1:0]   pc, pc_n, req_pc, req_pc_n;
  logic [XLEN-1:0]   redirect_tgt;
  logic              req_fire, push, pop;
  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [2*XLEN-1:0] head;

  assign redirect_tgt   = {redirect_pc[XLEN-1:2], 2'b00};
  // A request is only issued when a slot is free for its response.
  assign imem_req_valid = (state == REQ) && !fifo_full;
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign push           = (state == WAIT) && imem_rsp_valid && !redirect_valid;
  assign pop            = inst_valid && inst_ready;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_n  = state;
    pc_n     = pc;
    req_pc_n = req_pc;
    if (redirect_valid) pc_n = redirect_tgt;
    case (state)
      IDLE: state_n = REQ;
      REQ: begin
        if (redirect_valid) begin
          state_n = req_fire ? DRAIN : REQ;
        end else if (req_fire) begin
          req_pc_n = pc;
          pc_n     = pc + XLEN'(4);
          state_n  = WAIT;
        end
      end
      WAIT: begin
        if (redirect_valid)      state_n = imem_rsp_valid ? REQ : DRAIN;
        else if (imem_rsp_valid) state_n = REQ;
      end
      DRAIN: begin
        if (!redirect_valid && imem_rsp_valid) state_n = REQ;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      req_pc <= RESET_PC;
    end else begin
      state  <= state_n;
      pc     <= pc_n;
      req_pc <= req_pc_n;
    end
  end

  if_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2*XLEN)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({req_pc, imem_rsp_data}),
    .pop   (pop),
    .flush (redirect_valid),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign inst_valid = !fifo_empty;
  assign inst_pc    = head[2*XLEN-1:XLEN];
  assign inst       = head[XLEN-1:0];
  assign opcode     = inst[OPCODE_LSB +: 7];
  assign rd         = inst[RD_LSB     +: 5];
  assign funct3     = inst[FUNCT3_LSB +: 3];
  assign rs1        = inst[RS1_LSB    +: 5];
  assign rs2        = inst[RS2_LSB    +: 5];
  assign funct7     = inst[FUNCT7_LSB +: 7];

  a_count_in_range: assert property (@(posedge clk) disable iff (!rst_n)
    fifo_count <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: inputs change and outputs are sampled on the
// falling edge; memory responses are driven by hand, one step at a time.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_pc;
  logic [31:0] inst;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  funct7;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  if_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_pc        (inst_pc),
    .inst           (inst),
    .opcode         (opcode),
    .rd             (rd),
    .funct3         (funct3),
    .rs1            (rs1),
    .rs2            (rs2),
    .funct7         (funct7)
  );

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst_n          = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inst_ready     = 1'b0;
    step(); step();

    // Reset state
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_req_addr",  imem_req_addr,  32'h0);
    check("rst_inst_valid", inst_valid, 0);
    check("rst_inst",      inst,    32'h0);
    check("rst_inst_pc",   inst_pc, 32'h0);

    // Zero-wait fetch: release in the middle of cycle 1 (IDLE)
    rst_n = 1'b1;
    imem_req_ready = 1'b1;
    step();                                  // cycle 2: REQ
    check("t1_c2_inst_valid", inst_valid, 0);
    check("t1_c2_req_valid", imem_req_valid, 1);
    check("t1_c2_req_addr", imem_req_addr, 32'h0);
    step();                                  // cycle 3: WAIT
    check("t1_c3_inst_valid", inst_valid, 0);
    check("t1_c3_req_valid", imem_req_valid, 0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0050_0093;          // addi x1, x0, 5
    step();                                  // cycle 4
    imem_rsp_valid = 1'b0;
    check("t1_inst_valid", inst_valid, 1);
    check("t1_inst_pc", inst_pc, 32'h0);
    check("t1_inst", inst, 32'h0050_0093);
    check("t1_opcode", opcode, 7'b0010011);
    check("t1_rd", rd, 5'd1);
    check("t1_funct3", funct3, 3'd0);
    check("t1_rs1", rs1, 5'd0);
    check("t1_rs2", rs2, 5'd5);
    check("t1_funct7", funct7, 7'd0);
    check("t1_next_valid", imem_req_valid, 1);
    check("t1_next_addr", imem_req_addr, 32'h4);

    // Back-pressure from decode: FIFO fills with pc 0 and 4
    step();                                  // WAIT for addr 4
    check("t2_wait_req_valid", imem_req_valid, 0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h00A0_0113;          // addi x2, x0, 10
    step();
    imem_rsp_valid = 1'b0;
    check("t2_full_req_valid", imem_req_valid, 0);
    check("t2_full_head_pc", inst_pc, 32'h0);
    step();
    check("t2_full_req_valid2", imem_req_valid, 0);
    check("t2_full_addr", imem_req_addr, 32'h8);
    check("t2_full_head_pc2", inst_pc, 32'h0);
    inst_ready = 1'b1;
    step();                                  // pc 0 popped
    check("t2_pop1_valid", inst_valid, 1);
    check("t2_pop1_pc", inst_pc, 32'h4);
    check("t2_pop1_inst", inst, 32'h00A0_0113);
    check("t2_pop1_rd", rd, 5'd2);
    check("t2_resume_valid", imem_req_valid, 1);
    check("t2_resume_addr", imem_req_addr, 32'h8);
    step();                                  // pc 4 popped, addr 8 accepted
    inst_ready = 1'b0;
    check("t2_empty", inst_valid, 0);
    check("t2_wait8_req_valid", imem_req_valid, 0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0020_81B3;          // add x3, x1, x2
    step();
    imem_rsp_valid = 1'b0;
    check("t2_pc8_valid", inst_valid, 1);
    check("t2_pc8_pc", inst_pc, 32'h8);
    check("t2_pc8_rs1", rs1, 5'd1);
    check("t2_pc8_rs2", rs2, 5'd2);
    check("t2_pc8_opcode", opcode, 7'b0110011);
    check("t2_next_addr", imem_req_addr, 32'hC);

    // Asynchronous reset in the middle of operation
    rst_n = 1'b0;
    imem_req_ready = 1'b0;
    #1;
    check("arst_inst_valid", inst_valid, 0);
    check("arst_req_valid", imem_req_valid, 0);
    check("arst_req_addr", imem_req_addr, 32'h0);
    check("arst_inst_pc", inst_pc, 32'h0);
    step();

    // Stray response during IDLE is ignored; request held while ready=0
    rst_n = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    step();
    imem_rsp_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t3_hold%0d_valid", i), imem_req_valid, 1);
      check($sformatf("t3_hold%0d_addr", i), imem_req_addr, 32'h0);
      step();
    end
    check("t3_idle_rsp_ignored", inst_valid, 0);
    check("t3_c6_valid", imem_req_valid, 1);
    check("t3_c6_addr", imem_req_addr, 32'h0);
    imem_req_ready = 1'b1;
    step();                                  // accepted, WAIT
    check("t3_accepted", imem_req_valid, 0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0000_0013;
    step();
    imem_rsp_valid = 1'b0;
    check("t4_pre_valid", inst_valid, 1);
    check("t4_pre_addr", imem_req_addr, 32'h4);
    step();                                  // addr 4 accepted, WAIT

    // Redirect while WAIT: flush, drain the outstanding response
    check("t4_wait_req_valid", imem_req_valid, 0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0102;
    step();
    redirect_valid = 1'b0;
    check("t4_flushed", inst_valid, 0);
    check("t4_drain_req_valid", imem_req_valid, 0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hBAD0_0013;
    step();
    imem_rsp_valid = 1'b0;
    check("t4_dropped", inst_valid, 0);
    check("t4_req_valid", imem_req_valid, 1);
    check("t4_req_addr", imem_req_addr, 32'h0000_0100);
    step();                                  // addr 100 accepted
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0010_0093;
    step();
    imem_rsp_valid = 1'b0;
    check("t5_head_pc", inst_pc, 32'h100);
    check("t5_next_addr", imem_req_addr, 32'h104);
    step();                                  // addr 104 accepted, WAIT

    // Redirect coinciding with response and decode pop
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hBAD1_0013;
    inst_ready     = 1'b1;
    imem_req_ready = 1'b0;
    step();
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    inst_ready     = 1'b0;
    check("t5_no_push", inst_valid, 0);
    check("t5_inst_pc", inst_pc, 32'h0);
    check("t5_req_valid", imem_req_valid, 1);
    check("t5_req_addr", imem_req_addr, 32'h200);

    // Redirect in REQ without handshake, then PC wrap
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    check("t6_req_valid", imem_req_valid, 1);
    check("t6_req_addr", imem_req_addr, 32'hFFFF_FFFC);
    imem_req_ready = 1'b1;
    step();
    check("t6_wait_req_valid", imem_req_valid, 0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0000_006F;          // jal x0, 0
    step();
    imem_rsp_valid = 1'b0;
    check("t6_head_pc", inst_pc, 32'hFFFF_FFFC);
    check("t6_head_opcode", opcode, 7'b1101111);
    check("t6_wrap_valid", imem_req_valid, 1);
    check("t6_wrap_addr", imem_req_addr, 32'h0);

    // Redirect in REQ while the request handshakes: that response is drained
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0040;
    step();
    redirect_valid = 1'b0;
    check("t7_flushed", inst_valid, 0);
    check("t7_drain_req_valid", imem_req_valid, 0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hBAD2_0013;
    step();
    imem_rsp_valid = 1'b0;
    check("t7_dropped", inst_valid, 0);
    check("t7_req_valid", imem_req_valid, 1);
    check("t7_req_addr", imem_req_addr, 32'h40);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
